// File: rtl/iic_read_arbiter.sv
// rtl/iic_read_arbiter.sv - round-robin arbiter sharing one IIC read engine among NUM_REQ requesters
module iic_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [7*NUM_REQ-1:0] i_dev_addr,
    input  logic [8*NUM_REQ-1:0] i_word_addr,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [NUM_REQ-1:0]   o_err,
    output logic [7:0]           o_rd_data,
    output logic                 o_busy,
    output logic                 o_iic_recv_en,
    output logic [6:0]           o_dev_addr,
    output logic [7:0]           o_word_addr,
    input  logic                 i_done_flag,
    input  logic [7:0]           i_read_data
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NUM_REQ-1:0]  req_q;
    logic [NUM_REQ-1:0]  eligible;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       grant;
    logic [IW-1:0]       pick;
    logic [IW-1:0]       cand;
    logic                found;
    int                  s;
    logic [CW-1:0]       cnt;
    logic                err;
    logic                timeout_hit;
    logic [6:0]          dev_arr  [NUM_REQ];
    logic [7:0]          word_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_addr
        assign dev_arr[k]  = i_dev_addr[7*k +: 7];
        assign word_arr[k] = i_word_addr[8*k +: 8];
    end

    // A requester counts only if it was high at the last edge and still is, so a
    // requester that drops right after its ack is never re-granted from a stale sample.
    assign eligible    = req_q & i_req;
    assign timeout_hit = (cnt == CW'(TIMEOUT_CYC - 1));

    assign o_busy        = (state != ST_IDLE);
    assign o_iic_recv_en = (state == ST_WAIT);

    // Round-robin search starting just above the last served index.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        s     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            s = int'(ptr) + i;
            if (s >= NUM_REQ) begin
                s = s - NUM_REQ;
            end
            cand = IW'(s);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; done takes priority over the timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (found) state_nxt = ST_WAIT;
            ST_WAIT: if (i_done_flag || timeout_hit) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request sample register feeding the arbiter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_q <= '0;
        end else begin
            req_q <= i_req;
        end
    end

    // Grant capture, timeout counting, response capture and pointer update.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr         <= IW'(NUM_REQ - 1);
            grant       <= '0;
            cnt         <= '0;
            err         <= 1'b0;
            o_rd_data   <= 8'h00;
            o_dev_addr  <= 7'h00;
            o_word_addr <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant       <= pick;
                        o_dev_addr  <= dev_arr[pick];
                        o_word_addr <= word_arr[pick];
                        cnt         <= '0;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (i_done_flag) begin
                        o_rd_data <= i_read_data;
                        err       <= 1'b0;
                    end else if (timeout_hit) begin
                        o_rd_data <= 8'h00;
                        err       <= 1'b1;
                    end
                end
                ST_RESP: begin
                    ptr <= grant;
                end
                default: ;
            endcase
        end
    end

    // One-cycle ack/err pulse to the granted requester.
    always_comb begin
        o_ack = '0;
        o_err = '0;
        if (state == ST_RESP) begin
            o_ack[grant] = 1'b1;
            o_err[grant] = err;
        end
    end

endmodule

// File: tb/tb_iic_read_arbiter.sv
// tb/tb_iic_read_arbiter.sv - self-checking bench for iic_read_arbiter
module tb_iic_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [27:0] dev_bus;
    logic [31:0] word_bus;
    logic        done_flag;
    logic [7:0]  read_data;

    logic [3:0] ack_a, err_a, ack_b, err_b;
    logic [7:0] rd_a, rd_b, oword_a, oword_b;
    logic [6:0] odev_a, odev_b;
    logic       busy_a, en_a, busy_b, en_b;

    logic [6:0] dev_of  [4];
    logic [7:0] word_of [4];

    typedef struct {
        logic [3:0] ack;
        logic [3:0] err;
        logic [7:0] data;
    } resp_t;
    resp_t sb_q[$];

    typedef struct {
        bit         do_rst;
        logic [3:0] req;
        bit         drop;
        int         delay;
        logic [7:0] data;
        int         g;
    } vec_t;
    vec_t vt[10];

    int n_tests = 0;
    int n_fail  = 0;
    int low_run = 100;

    always #5 clk = ~clk;

    iic_read_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(4096)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_dev_addr(dev_bus), .i_word_addr(word_bus),
        .o_ack(ack_a), .o_err(err_a), .o_rd_data(rd_a), .o_busy(busy_a),
        .o_iic_recv_en(en_a), .o_dev_addr(odev_a), .o_word_addr(oword_a),
        .i_done_flag(done_flag), .i_read_data(read_data)
    );

    iic_read_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut_to (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_dev_addr(dev_bus), .i_word_addr(word_bus),
        .o_ack(ack_b), .o_err(err_b), .o_rd_data(rd_b), .o_busy(busy_b),
        .o_iic_recv_en(en_b), .o_dev_addr(odev_b), .o_word_addr(oword_b),
        .i_done_flag(done_flag), .i_read_data(read_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_addr();
        dev_bus  = {dev_of[3], dev_of[2], dev_of[1], dev_of[0]};
        word_bus = {word_of[3], word_of[2], word_of[1], word_of[0]};
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic wait_en(input bit on_b, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((on_b ? en_b : en_a) == 1'b1) begin
                ok  = 1'b1;
                cyc = i;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_en: actual=low for 200 cycles required=high");
        end
    endtask

    task automatic pulse_done(input logic [7:0] d, input logic [3:0] exp_ack, input bit push);
        done_flag = 1'b1;
        read_data = d;
        if (push) sb_q.push_back('{exp_ack, 4'd0, d});
        @(posedge clk);
        #1;
        done_flag = 1'b0;
        read_data = 8'($urandom);
    endtask

    // Starts at the falling edge of the first WAIT cycle.
    task automatic txn_body(input int g, input int delay, input logic [7:0] d, input bit drop);
        check("dev_addr", 32'(odev_a), 32'(dev_of[g]));
        check("word_addr", 32'(oword_a), 32'(word_of[g]));
        step(delay);
        pulse_done(d, 4'(1 << g), 1'b1);
        if (drop) req[g] = 1'b0;
    endtask

    task automatic run_txn(input int g, input int delay, input logic [7:0] d, input bit drop);
        bit ok;
        int cyc;
        wait_en(1'b0, ok, cyc);
        if (ok) txn_body(g, delay, d, drop);
    endtask

    // Response scoreboard and enable-gap monitor for the main instance.
    always @(negedge clk) begin
        resp_t e;
        if (rst) begin
            low_run = 100;
        end else begin
            if (en_a) begin
                if (low_run != 0) begin
                    n_tests++;
                    if (low_run < 2) begin
                        n_fail++;
                        $display("FAIL en_gap: actual=%0d required>=2", low_run);
                    end
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            if (ack_a != 4'd0) begin
                check("ack_en_low", 32'(en_a), 32'd0);
                check("ack_busy", 32'(busy_a), 32'd1);
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: actual=%0h required=0", ack_a);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_ack", 32'(ack_a), 32'(e.ack));
                    check("sb_err", 32'(err_a), 32'(e.err));
                    check("sb_data", 32'(rd_a), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int cyc;

        rst = 1'b1; req = 4'd0; done_flag = 1'b0; read_data = 8'h00;
        dev_of[0] = 7'h6D; dev_of[1] = 7'h12; dev_of[2] = 7'h35; dev_of[3] = 7'h7A;
        word_of[0] = 8'hE9; word_of[1] = 8'h44; word_of[2] = 8'h81; word_of[3] = 8'h0F;
        drive_addr();

        vt[0] = '{1'b0, 4'b0100, 1'b1, 3,  8'h11, 2};
        vt[1] = '{1'b0, 4'b0011, 1'b1, 5,  8'h22, 0};
        vt[2] = '{1'b0, 4'b0010, 1'b1, 7,  8'h33, 1};
        vt[3] = '{1'b0, 4'b1001, 1'b1, 2,  8'h44, 3};
        vt[4] = '{1'b0, 4'b0001, 1'b1, 0,  8'h55, 0};
        vt[5] = '{1'b1, 4'b1111, 1'b0, 10, 8'hA0, 0};
        vt[6] = '{1'b0, 4'b1111, 1'b0, 10, 8'hA1, 1};
        vt[7] = '{1'b0, 4'b1111, 1'b0, 10, 8'hA2, 2};
        vt[8] = '{1'b0, 4'b1111, 1'b0, 10, 8'hA3, 3};
        vt[9] = '{1'b0, 4'b1111, 1'b0, 10, 8'hA4, 0};

        // reset state
        step(1);
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_data", 32'(rd_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_en", 32'(en_a), 32'd0);
        check("rst_dev", 32'(odev_a), 32'd0);
        check("rst_word", 32'(oword_a), 32'd0);
        step(1);
        rst = 1'b0;

        // latency and single request with 40-cycle engine
        step(1);
        req = 4'b0001;
        step(1);
        check("lat_after_n", 32'(en_a), 32'd0);
        wait_en(1'b0, ok, cyc);
        check("lat_after_n1", 32'(cyc), 32'd1);
        if (ok) txn_body(0, 40, 8'hB4, 1'b1);

        // table: mixed request patterns, then round-robin with all held
        for (int i = 0; i < 10; i++) begin
            if (vt[i].do_rst) do_reset();
            req = vt[i].req;
            run_txn(vt[i].g, vt[i].delay, vt[i].data, vt[i].drop);
        end
        req = 4'd0;

        // address hold while requester drops out mid-transaction
        do_reset();
        req = 4'b0010;
        wait_en(1'b0, ok, cyc);
        word_of[1] = 8'hC3; dev_of[1] = 7'h01; drive_addr();
        req = 4'b0000;
        step(3);
        check("hold_word", 32'(oword_a), 32'h44);
        check("hold_dev", 32'(odev_a), 32'h12);
        check("hold_en", 32'(en_a), 32'd1);
        pulse_done(8'h3C, 4'b0010, 1'b1);
        word_of[1] = 8'h44; dev_of[1] = 7'h12; drive_addr();

        // stray done in IDLE
        step(3);
        done_flag = 1'b1; read_data = 8'hEE;
        step(1);
        done_flag = 1'b0;
        check("stray_ack", 32'(ack_a), 32'd0);
        check("stray_busy", 32'(busy_a), 32'd0);
        check("stray_data", 32'(rd_a), 32'h3C);
        step(2);
        check("stray_ack2", 32'(ack_a), 32'd0);

        // reset in the middle of WAIT
        req = 4'b0100;
        wait_en(1'b0, ok, cyc);
        step(5);
        rst = 1'b1;
        #1;
        check("midrst_en", 32'(en_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_dev", 32'(odev_a), 32'd0);
        check("midrst_ack", 32'(ack_a), 32'd0);
        req = 4'b0101;
        step(2);
        rst = 1'b0;
        run_txn(0, 4, 8'h66, 1'b1);
        run_txn(2, 4, 8'h77, 1'b1);

        // done on the final timeout cycle, then a real timeout (16-cycle instance)
        do_reset();
        req = 4'b0001;
        wait_en(1'b1, ok, cyc);
        if (ok) begin
            step(15);
            check("coll_en", 32'(en_b), 32'd1);
            pulse_done(8'h5A, 4'b0001, 1'b1);
            check("coll_ack", 32'(ack_b), 32'b0001);
            check("coll_err", 32'(err_b), 32'd0);
            check("coll_data", 32'(rd_b), 32'h5A);
            wait_en(1'b1, ok, cyc);
            if (ok) begin
                step(15);
                check("to_pre_ack", 32'(ack_b), 32'd0);
                check("to_pre_en", 32'(en_b), 32'd1);
                step(1);
                check("to_ack", 32'(ack_b), 32'b0001);
                check("to_err", 32'(err_b), 32'b0001);
                check("to_data", 32'(rd_b), 32'h00);
                check("to_en", 32'(en_b), 32'd0);
                req = 4'd0;
                step(1);
                check("to_ack_off", 32'(ack_b), 32'd0);
                check("to_busy_off", 32'(busy_b), 32'd0);
            end
        end
        req = 4'd0;

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iic_read_arbiter.md
IIC_READ_ARBITER -- requirements
Module: iic_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports, range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 4096: maximum cycles to wait for engine done, range >= 16.
REQ-003 Port i_clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port i_rst  input  1: asynchronous, active-high reset.
REQ-005 Port i_req  input  NUM_REQ: level request per requester; held high until that requester's o_ack.
REQ-006 Port i_dev_addr  input  7*NUM_REQ: 7-bit device address for requester k at bits [7k+6:7k].
REQ-007 Port i_word_addr  input  8*NUM_REQ: 8-bit word address for requester k at bits [8k+7:8k].
REQ-008 Port o_ack  output  NUM_REQ: one-cycle completion pulse to the granted requester.
REQ-009 Port o_err  output  NUM_REQ: one-cycle timeout flag, coincident with the o_ack bit of the same requester.
REQ-010 Port o_rd_data  output  8: read byte; valid only while any o_ack bit is high.
REQ-011 Port o_busy  output  1: high from grant through the response cycle.
REQ-012 Port o_iic_recv_en  output  1: enable to the IIC receive engine.
REQ-013 Port o_dev_addr  output  7: device address to the engine.
REQ-014 Port o_word_addr  output  8: word address to the engine.
REQ-015 Port i_done_flag  input  1: engine single-cycle completion pulse.
REQ-016 Port i_read_data  input  8: engine read byte, valid when i_done_flag is high.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and RESP, encoded in 2 bits.
REQ-018 IDLE: when i_req is non-zero, the FSM SHALL grant round-robin, searching from index ptr+1 upward with modulo-NUM_REQ wrap.
REQ-019 On grant, the block SHALL latch the grant index and that requester's addresses into o_dev_addr and o_word_addr, set o_busy, clear the timeout counter and go to WAIT.
REQ-020 Latency: a request sampled at edge N SHALL produce o_iic_recv_en high after edge N+1.
REQ-021 WAIT: o_iic_recv_en SHALL be high, and o_dev_addr and o_word_addr SHALL stay stable whatever i_dev_addr, i_word_addr and i_req do.
REQ-022 WAIT: on i_done_flag, the block SHALL capture i_read_data into o_rd_data and go to RESP with err=0.
REQ-023 WAIT: the timeout counter SHALL increment every cycle; at TIMEOUT_CYC-1 with no done, the block SHALL set o_rd_data=8'h00 and go to RESP with err=1.
REQ-024 If done and timeout occur in the same cycle, done SHALL win (err=0, data captured).
REQ-025 RESP: for exactly one cycle, o_iic_recv_en=0, o_ack[grant]=1 and o_err[grant]=err; then ptr is set to the grant index, o_busy is cleared and the FSM goes to IDLE.
REQ-026 o_iic_recv_en SHALL be low for at least 2 consecutive cycles between transactions (the RESP and IDLE cycles).
REQ-027 i_done_flag outside WAIT SHALL be ignored, with no state change.
REQ-028 If a requester drops i_req during WAIT, the transaction SHALL still complete and o_ack SHALL still pulse; no abort.
REQ-029 At most one o_ack bit SHALL be high in any cycle, and o_ack SHALL be zero outside RESP.
REQ-030 A requester that holds i_req after its ack SHALL become eligible again only after all other pending requesters are served.

Reset
REQ-031 While i_rst is high, all outputs SHALL be 0 immediately (asynchronous): o_iic_recv_en, o_ack, o_err, o_rd_data, o_busy, o_dev_addr and o_word_addr.
REQ-032 Reset SHALL put the FSM in IDLE, the counter at 0 and ptr at NUM_REQ-1, so requester 0 wins first.
REQ-033 Reset asserted in WAIT SHALL abort the transaction silently, with no ack after release.
REQ-034 The first grant after reset release SHALL occur no earlier than the first rising edge with i_rst low.

Verification
REQ-035 Single request: i_req=4'b0001, dev=7'h6D, word=8'hE9; engine done after 40 cycles with data 8'hB4 -> o_dev_addr=7'h6D and o_word_addr=8'hE9 during WAIT, then o_ack=4'b0001 with o_rd_data=8'hB4 and o_err=0.
REQ-036 Round-robin: i_req=4'b1111 held, with each engine done after 10 cycles -> grant order 0,1,2,3,0, with exactly one ack per transaction.
REQ-037 Timeout: TIMEOUT_CYC=16 and no done -> o_ack[g]=o_err[g]=1 with o_rd_data=8'h00 exactly 16 cycles after en rises.
REQ-038 Collision: done on the final timeout cycle -> o_err=0 and the data is captured.
REQ-039 Mid-op reset: assert i_rst 5 cycles into WAIT -> o_iic_recv_en=0 the same cycle, no ack, and requester 0 is served first after release.
REQ-040 Address hold: change i_word_addr for the granted requester during WAIT -> o_word_addr unchanged; a stray done in IDLE -> no ack.
